asym_ram_rd_streamer: RTL

Read-side engine for the narrow port of the asymmetric write-wider sample/envelope RAM. On a start command it walks the narrow-word address space from a start address for a given length. It hides the RAM's fixed 3-cycle read pipeline behind a credit-tracked output FIFO. It presents the words as a valid/ready stream with a last flag, so DSP or DAC consumers can apply backpressure without losing data.

---
 rtl/asym_ram_pkg.sv | 15 +
 rtl/sync_fifo_fwft.sv | 58 +++++
 rtl/asym_ram_rd_streamer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/asym_ram_pkg.sv
// Shared definitions for the asymmetric sample/envelope RAM and its narrow-port read streamer.
package asym_ram_pkg;

    localparam int RAM_RD_LATENCY = 3;
    localparam int DATAWIDTH_DEF  = 4;
    localparam int ADDRWIDTH_DEF  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } streamState_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with occupancy count; head word is visible whenever not empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    output logic [WIDTH-1:0]           popData,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             full;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr];

    // Push at full is legal only together with a pop, which frees the slot being overwritten.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            assert (!(push && full && !doPop));
            if (push)
                wrPtr <= wrPtr + AW'(1);
            if (doPop)
                rdPtr <= rdPtr + AW'(1);
            if (push && !doPop)
                count <= count + (AW+1)'(1);
            else if (!push && doPop)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/asym_ram_rd_streamer.sv
// Narrow-port burst reader: issues RAM reads under FIFO credit and streams the words out
// as valid/ready with a last flag, hiding the fixed RAM read pipeline.
module asym_ram_rd_streamer
    import asym_ram_pkg::*;
#(
    parameter int DATAWIDTH  = DATAWIDTH_DEF,
    parameter int ADDRWIDTH  = ADDRWIDTH_DEF,
    parameter int LENWIDTH   = 11,
    parameter int RD_LATENCY = RAM_RD_LATENCY,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] start_addr,
    input  logic [LENWIDTH-1:0]  length,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH-1:0] ram_addr,
    input  logic [DATAWIDTH-1:0] ram_dout,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    localparam int CW  = $clog2(FIFO_DEPTH + RD_LATENCY + 2);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    streamState_t        state, stateNext;
    logic [LENWIDTH-1:0] remaining;
    logic [RD_LATENCY:0] pipeValid;
    logic [RD_LATENCY:0] pipeLast;
    logic                issueNow, issueLast, doneNext, fifoClear, fifoPush, pop, creditOk;
    logic [FCW-1:0]      fifoCount;
    logic                fifoEmpty;
    logic [DATAWIDTH:0]  headWord;
    logic [CW-1:0]       occupancy;

    assign busy      = (state != IDLE);
    assign pop       = m_valid & m_ready;
    // Stage 0 of the tag pipe is aligned with ram_addr; the top stage lines up with ram_dout.
    assign occupancy = CW'($countones(pipeValid)) + CW'(fifoCount) - CW'(pop);
    assign creditOk  = (occupancy < CW'(FIFO_DEPTH));
    assign fifoPush  = pipeValid[RD_LATENCY] && (state != FLUSH) && !fifoClear;

    assign m_valid = !fifoEmpty;
    assign m_data  = fifoEmpty ? '0 : headWord[DATAWIDTH-1:0];
    assign m_last  = !fifoEmpty && headWord[DATAWIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // The first read is issued straight from IDLE; nothing is in flight or buffered there.
    always_comb begin
        stateNext = state;
        doneNext  = 1'b0;
        issueNow  = 1'b0;
        issueLast = 1'b0;
        fifoClear = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !done) begin
                    if (length == '0) begin
                        doneNext = 1'b1;
                    end else begin
                        issueNow  = 1'b1;
                        issueLast = (length == LENWIDTH'(1));
                        stateNext = (length == LENWIDTH'(1)) ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    fifoClear = 1'b1;
                    stateNext = FLUSH;
                end else if (creditOk) begin
                    issueNow  = 1'b1;
                    issueLast = (remaining == LENWIDTH'(1));
                    if (remaining == LENWIDTH'(1))
                        stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    fifoClear = 1'b1;
                    stateNext = FLUSH;
                end else if (pop && m_last) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            FLUSH: begin
                if (pipeValid[RD_LATENCY-1:0] == '0) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done      <= 1'b0;
            ram_addr  <= '0;
            remaining <= '0;
            pipeValid <= '0;
            pipeLast  <= '0;
        end else begin
            done      <= doneNext;
            pipeValid <= {pipeValid[RD_LATENCY-1:0], issueNow};
            pipeLast  <= {pipeLast[RD_LATENCY-1:0], issueLast};
            if (issueNow) begin
                if (state == IDLE) begin
                    ram_addr  <= start_addr;
                    remaining <= length - LENWIDTH'(1);
                end else begin
                    ram_addr  <= ram_addr + ADDRWIDTH'(1);
                    remaining <= remaining - LENWIDTH'(1);
                end
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH(DATAWIDTH + 1),
        .DEPTH(FIFO_DEPTH)
    ) outFifo (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (fifoClear),
        .push    (fifoPush),
        .pushData({pipeLast[RD_LATENCY], ram_dout}),
        .pop     (pop),
        .popData (headWord),
        .empty   (fifoEmpty),
        .count   (fifoCount)
    );

endmodule
